carry_lookahead_adder: RTL and testbench

CARRY_LOOKAHEAD_ADDER -- requirements
Module: carry_lookahead_adder

---
 rtl/carry_lookahead_pkg.sv | 24 ++
 rtl/full_adder.sv | 23 ++
 rtl/carry_lookahead_adder.sv | 79 +++++++
 tb/tb_carry_lookahead_adder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/carry_lookahead_pkg.sv
`default_nettype none
// ============================================================================
// Module  : carry_lookahead_pkg
// Purpose : Shared constants and a behavioural reference sum used by the
//           carry-lookahead adder and its benches.
// Contents: MAX_WIDTH - widest legal operand width
//           ref_sum() - unsigned, zero-extended sum of two operands
// Revision: 1.0 - initial release
// ============================================================================
package carry_lookahead_pkg;

    localparam int MAX_WIDTH = 32;

    // Operands are zero-extended to MAX_WIDTH+1 bits, so the carry-out always
    // lands in the result and no overflow is ever lost.
    function automatic logic [MAX_WIDTH:0] ref_sum(
        input logic [MAX_WIDTH-1:0] add1,
        input logic [MAX_WIDTH-1:0] add2
    );
        return {1'b0, add1} + {1'b0, add2};
    endfunction

endpackage : carry_lookahead_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module  : full_adder
// Purpose : One-bit full adder producing the sum bit of one adder column.
// Ports   : i_bit1, i_bit2 - operand bits
//           i_carry        - carry into this column
//           o_sum          - sum bit
//           o_carry        - carry out of this column
// Revision: 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_bit1,
    input  logic i_bit2,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_bit1 ^ i_bit2 ^ i_carry;
    assign o_carry = (i_bit1 & i_bit2) | (i_carry & (i_bit1 ^ i_bit2));

endmodule : full_adder
`default_nettype wire

// File: rtl/carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module  : carry_lookahead_adder
// Purpose : WIDTH-bit unsigned adder with generate/propagate carry lookahead,
//           a combinational sum output and a registered copy of that sum.
// Ports   : i_clk      - clock, rising edge active
//           i_rst      - synchronous active-high reset (registered path only)
//           i_add1     - first unsigned addend  [WIDTH-1:0]
//           i_add2     - second unsigned addend [WIDTH-1:0]
//           o_result   - combinational sum, MSB is carry-out [WIDTH:0]
//           o_result_q - o_result registered once per clock  [WIDTH:0]
// Revision: 1.0 - initial release
// ============================================================================
module carry_lookahead_adder
    import carry_lookahead_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result,
    output logic [WIDTH:0]   o_result_q
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("carry_lookahead_adder: WIDTH out of range 1..%0d", MAX_WIDTH);
    end

    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_fa_carry;
    logic [WIDTH:0]   r_result_q;

    assign w_gen     = i_add1 & i_add2;
    assign w_prop    = i_add1 | i_add2;
    assign w_carry[0] = 1'b0;

    // Carries come from generate/propagate terms here rather than from the
    // full adders' own carry outputs, keeping the carry network in one place.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign w_carry[i+1] = w_gen[i] | (w_prop[i] & w_carry[i]);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_full_adder (
            .i_bit1  (i_add1[i]),
            .i_bit2  (i_add2[i]),
            .i_carry (w_carry[i]),
            .o_sum   (w_sum[i]),
            .o_carry (w_fa_carry[i])
        );
    end

    // The full adders' local carries must agree with the lookahead network;
    // a disagreement means one of the two carry formulations is broken.
    always_comb begin
        if (!$isunknown({i_add1, i_add2})) begin
            a_carry_agree : assert (w_fa_carry == w_carry[WIDTH:1]);
        end
    end

    assign o_result = {w_carry[WIDTH], w_sum};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result_q <= '0;
        end else begin
            r_result_q <= o_result;
        end
    end

    assign o_result_q = r_result_q;

endmodule : carry_lookahead_adder
`default_nettype wire

// File: tb/tb_carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_carry_lookahead_adder
// Purpose : Self-checking bench for carry_lookahead_adder at WIDTH=3 and
//           WIDTH=8: boundary table, exhaustive 3-bit sweep, registered-path
//           and reset sequences, random 8-bit pairs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_carry_lookahead_adder;
    import carry_lookahead_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] a3, b3;
    logic [3:0] res3, res3_q;
    logic [7:0] a8, b8;
    logic [8:0] res8, res8_q;

    int vectors;
    int miscompares;

    carry_lookahead_adder #(.WIDTH(3)) dut3 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_add1     (a3),
        .i_add2     (b3),
        .o_result   (res3),
        .o_result_q (res3_q)
    );

    carry_lookahead_adder #(.WIDTH(8)) dut8 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_add1     (a8),
        .i_add2     (b8),
        .o_result   (res8),
        .o_result_q (res8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] expected;
    } vec3_t;

    task automatic check(input string name, input logic [32:0] actual,
                         input logic [32:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Apply a 3-bit pair at the falling edge, check the combinational sum at
    // once and the registered sum just after the following rising edge.
    task automatic apply3(input string name, input logic [2:0] a, input logic [2:0] b,
                          input logic [3:0] expected);
        @(negedge clk);
        a3 = a;
        b3 = b;
        #1;
        check({name, " comb"}, 33'(res3), 33'(expected));
        @(posedge clk);
        #1;
        check({name, " reg"}, 33'(res3_q), 33'(expected));
    endtask

    task automatic apply8(input string name, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] expected;
        logic [32:0] pkg_sum;
        expected = 9'(a) + 9'(b);
        pkg_sum  = ref_sum(32'(a), 32'(b));
        @(negedge clk);
        a8 = a;
        b8 = b;
        #1;
        check({name, " comb"}, 33'(res8), 33'(expected));
        check({name, " pkgref"}, 33'(res8), pkg_sum);
        @(posedge clk);
        #1;
        check({name, " reg"}, 33'(res8_q), 33'(expected));
    endtask

    initial begin
        vec3_t table3[4];
        vectors     = 0;
        miscompares = 0;

        table3[0] = '{a: 3'd0, b: 3'd0, expected: 4'd0};
        table3[1] = '{a: 3'd7, b: 3'd7, expected: 4'b1110};
        table3[2] = '{a: 3'd7, b: 3'd1, expected: 4'd8};
        table3[3] = '{a: 3'd5, b: 3'd2, expected: 4'd7};

        // Reset with nonzero inputs: register must hold zero, sum stays live.
        rst = 1'b1;
        a3  = 3'd6;
        b3  = 3'd3;
        a8  = 8'd200;
        b8  = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        check("reset q3", 33'(res3_q), 33'd0);
        check("reset q8", 33'(res8_q), 33'd0);
        check("reset comb3", 33'(res3), 33'd9);
        check("reset comb8", 33'(res8), 33'd300);

        // First edge after reset release loads the current sum.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release q3", 33'(res3_q), 33'd9);

        // Boundary table.
        for (int i = 0; i < 4; i++) begin
            apply3($sformatf("bound%0d", i), table3[i].a, table3[i].b, table3[i].expected);
        end

        // Exhaustive 3-bit sweep.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                apply3($sformatf("exh %0d+%0d", a, b), 3'(a), 3'(b), 4'(a + b));
            end
        end

        // Registered path: a change shows up combinationally at once and in
        // the register only after the next edge.
        apply3("regpath 3+4", 3'd3, 3'd4, 4'd7);
        @(negedge clk);
        a3 = 3'd6;
        b3 = 3'd6;
        #1;
        check("regpath 6+6 comb", 33'(res3), 33'd12);
        check("regpath 6+6 q hold", 33'(res3_q), 33'd7);
        @(posedge clk);
        #1;
        check("regpath 6+6 q", 33'(res3_q), 33'd12);

        // Reset mid-stream discards the registered value for that edge.
        apply3("midrst 5+5", 3'd5, 3'd5, 4'd10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst comb asserted", 33'(res3), 33'd10);
        @(posedge clk);
        #1;
        check("midrst q cleared", 33'(res3_q), 33'd0);
        check("midrst comb during", 33'(res3), 33'd10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst q still zero", 33'(res3_q), 33'd0);
        @(posedge clk);
        #1;
        check("midrst q reload", 33'(res3_q), 33'd10);

        // 8-bit corner plus random pairs.
        apply8("w8 255+255", 8'd255, 8'd255);
        apply8("w8 0+0", 8'd0, 8'd0);
        apply8("w8 255+1", 8'd255, 8'd1);
        for (int n = 0; n < 1000; n++) begin
            apply8($sformatf("w8 rand%0d", n), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule : tb_carry_lookahead_adder
`default_nettype wire
